// File: rtl/btn_pulse.sv
// btn_pulse -- push-button conditioner: synchronizer, debouncer and
// press-pulse generator for a downstream counter's increment input.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable synchronized cycles needed to accept
//                    a change of the button level (1..255)
//   REPEAT_DELAY     cycles from the press pulse to the first auto-repeat
//                    pulse (auto-repeat build only)
//   REPEAT_PERIOD    cycles between auto-repeat pulses (auto-repeat build only)
//
// Ports
//   clk     in   system clock, all state changes on the rising edge
//   rst     in   asynchronous active-high reset
//   btn_in  in   raw asynchronous bouncing button level (1 = pressed)
//   level   out  debounced button level, registered
//   pulse   out  one-cycle registered strobe issued on each accepted press
//
// Configuration
//   BTN_PULSE_AUTO_REPEAT_EN  when defined, a held button keeps producing
//                             pulses (REPEAT state and repeat counter exist);
//                             when undefined, one pulse per press only.
module btn_pulse #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_PULSE_AUTO_REPEAT_EN
  // A delay or period of 1 would put two pulses on adjacent cycles; the
  // repeat spacing is clamped to 2 so a low cycle always separates pulses.
  localparam int DLY_EFF = (REPEAT_DELAY  < 2) ? 2 : REPEAT_DELAY;
  localparam int PER_EFF = (REPEAT_PERIOD < 2) ? 2 : REPEAT_PERIOD;
  localparam int RMAX    = (DLY_EFF > PER_EFF) ? DLY_EFF : PER_EFF;
  localparam int RW      = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(DLY_EFF - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(PER_EFF - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [RW-1:0] rcnt, rcnt_n;
`else
  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  // Repeat timing has no meaning in the single-pulse build.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

  state_t        state, state_n;
  logic          btn_meta, btn_sync;
  logic [CW-1:0] cnt, cnt_n;
  logic          level_n, pulse_n;
  logic          accept;

  // Debounce: count cycles of disagreement between the synchronized input
  // and the accepted level; any agreement restarts the count, so only a
  // full run of DEBOUNCE_CYCLES disagreeing cycles is accepted.
  always_comb begin
    accept = 1'b0;
    cnt_n  = cnt;
    if (btn_sync == level) begin
      cnt_n = '0;
    end else if (cnt == CNT_LAST) begin
      cnt_n  = '0;
      accept = 1'b1;
    end else begin
      cnt_n = cnt + 1'b1;
    end
  end

  // Next-state and output logic. An accepted release always wins over a
  // repeat pulse due on the same edge.
  always_comb begin
    state_n = state;
    level_n = level;
    pulse_n = 1'b0;
`ifdef BTN_PULSE_AUTO_REPEAT_EN
    rcnt_n  = rcnt;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = HELD;
          level_n = 1'b1;
          pulse_n = 1'b1;
`ifdef BTN_PULSE_AUTO_REPEAT_EN
          rcnt_n  = '0;
`endif
        end
      end
      HELD: begin
        if (accept) begin
          state_n = IDLE;
          level_n = 1'b0;
`ifdef BTN_PULSE_AUTO_REPEAT_EN
        end else if (rcnt == DLY_LAST) begin
          state_n = REPEAT;
          pulse_n = 1'b1;
          rcnt_n  = '0;
        end else begin
          rcnt_n  = rcnt + 1'b1;
`endif
        end
      end
`ifdef BTN_PULSE_AUTO_REPEAT_EN
      REPEAT: begin
        if (accept) begin
          state_n = IDLE;
          level_n = 1'b0;
        end else if (rcnt == PER_LAST) begin
          pulse_n = 1'b1;
          rcnt_n  = '0;
        end else begin
          rcnt_n  = rcnt + 1'b1;
        end
      end
`endif
      default: begin
        state_n = IDLE;
        level_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      cnt      <= '0;
      state    <= IDLE;
      level    <= 1'b0;
      pulse    <= 1'b0;
`ifdef BTN_PULSE_AUTO_REPEAT_EN
      rcnt     <= '0;
`endif
    end else begin
      btn_meta <= btn_in;
      btn_sync <= btn_meta;
      cnt      <= cnt_n;
      state    <= state_n;
      level    <= level_n;
      pulse    <= pulse_n;
`ifdef BTN_PULSE_AUTO_REPEAT_EN
      rcnt     <= rcnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_btn_pulse.sv
// tb_btn_pulse -- directed table-driven bench for btn_pulse with default
// parameters, plus hand-written reset and auto-repeat sequences.
module tb_btn_pulse;

  logic clk;
  logic rst;
  logic btn_in;
  logic level;
  logic pulse;

  int checks   = 0;
  int failures = 0;

  btn_pulse dut (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_in),
    .level  (level),
    .pulse  (pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic btn;
    logic lvl;
    logic pls;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic b, input logic l, input logic p);
    vec_t v;
    v.btn = b;
    v.lvl = l;
    v.pls = p;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Press held: level and pulse on the 6th edge, pulse gone on the 7th.
    add(5, 1'b1, 1'b0, 1'b0);
    add(1, 1'b1, 1'b1, 1'b1);
    add(1, 1'b1, 1'b1, 1'b0);
    // Release held: level falls on the 6th edge, no pulse.
    add(5, 1'b0, 1'b1, 1'b0);
    add(2, 1'b0, 1'b0, 1'b0);
    // Three-cycle glitch: ignored.
    add(3, 1'b1, 1'b0, 1'b0);
    add(6, 1'b0, 1'b0, 1'b0);
    // Ten cycles of toggling, then held: one pulse 6 edges after final rise.
    for (int i = 0; i < 5; i++) begin
      add(1, 1'b1, 1'b0, 1'b0);
      add(1, 1'b0, 1'b0, 1'b0);
    end
    add(5, 1'b1, 1'b0, 1'b0);
    add(1, 1'b1, 1'b1, 1'b1);
    add(1, 1'b1, 1'b1, 1'b0);
    add(5, 1'b0, 1'b1, 1'b0);
    add(2, 1'b0, 1'b0, 1'b0);

    // Reset state.
    rst    = 1'b1;
    btn_in = 1'b0;
    #2;
    chk("reset_level", level, 1'b0);
    chk("reset_pulse", pulse, 1'b0);
    step();
    step();
    chk("reset_level_clk", level, 1'b0);
    chk("reset_pulse_clk", pulse, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      btn_in = tbl[i].btn;
      step();
      chk($sformatf("tbl[%0d].level", i), level, tbl[i].lvl);
      chk($sformatf("tbl[%0d].pulse", i), pulse, tbl[i].pls);
    end

    // Asynchronous reset mid-debounce with button held through it.
    btn_in = 1'b1;
    for (int k = 1; k <= 3; k++) step();
    #3;
    rst = 1'b1;
    #1;
    chk("rst_mid_debounce_level", level, 1'b0);
    chk("rst_mid_debounce_pulse", pulse, 1'b0);
    step();
    chk("rst_hold_level", level, 1'b0);
    #3;
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("after_rst[%0d].level", k), level, (k >= 6));
      chk($sformatf("after_rst[%0d].pulse", k), pulse, (k == 6));
    end

    // Asynchronous reset clears an accepted level without a clock edge.
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async_level", level, 1'b0);
    chk("rst_async_pulse", pulse, 1'b0);
    btn_in = 1'b0;
    step();
    #3;
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) step();

`ifdef BTN_PULSE_AUTO_REPEAT_EN
    // Held for 30 cycles: pulses at P=6, P+8, then every 4, none after release.
    for (int e = 1; e <= 45; e++) begin
      btn_in = (e <= 30);
      step();
      chk($sformatf("repeat[%0d].level", e), level, (e >= 6 && e < 36));
      chk($sformatf("repeat[%0d].pulse", e), pulse,
          (e == 6) || (e >= 14 && e < 36 && ((e - 14) % 4 == 0)));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
